irq_sequencer: RTL and testbench
================================

IRQ_SEQUENCER -- requirements
Module: irq_sequencer

Interface
REQ-001 SHALL have parameter VECTOR_BASE, default 16'hFFE0: address of vector for line 0.
REQ-002 SHALL have parameter NUM_IRQ, default 16: number of interrupt lines, 1..16.
REQ-003 SHALL have port clk  in  1: single clock; all state updates on posedge.
REQ-004 SHALL have port srst  in  1: synchronous, active-high reset.
REQ-005 SHALL have port irq_req  in  NUM_IRQ: level interrupt requests.
REQ-006 SHALL have port irq_ack  out  NUM_IRQ: one-hot, one-cycle acknowledge.
REQ-007 SHALL have port boundary  in  1: CPU is at an instruction boundary.
REQ-008 SHALL have port reti_req  in  1: CPU decoded RETI; one-cycle pulse.
REQ-009 SHALL have port busy  out  1: sequencer owns register file and bus; CPU stalls.
REQ-010 SHALL have port flags  in  16: current SR; bit 3 = GIE.
REQ-011 SHALL have ports reg_regno out 4, reg_store out 1, reg_data out 16, reg_value in 16, reg_as out 2, reg_bytemode out 1, reg_post_inc out 1, reg_sp_dec out 1: register-file access port.
REQ-012 SHALL have ports mem_addr out 16, mem_wdata out 16, mem_we out 1, mem_re out 1, mem_rdata in 16, mem_ready in 1: word memory bus.

Function
REQ-013 reg_as and reg_bytemode SHALL be driven 0 at all times.
REQ-014 States: IDLE, PUSH_ADDR, PUSH_DATA, PUSH_WR, CLR_SR, VEC_RD, POP_ADDR, POP_RD; a phase bit selects PC (first) or SR (second).
REQ-015 IDLE -> PUSH_ADDR(PC) when boundary=1, flags[3]=1 and any irq_req bit set; highest index wins; index latched.
REQ-016 IDLE -> POP_ADDR(SR) when reti_req=1; if reti_req and interrupt entry coincide, reti_req wins.
REQ-017 PUSH_ADDR: regno=1, sp_dec=1 for exactly one cycle; reg_value (SP-2) latched as push address.
REQ-018 PUSH_DATA: sp_dec=0, regno=0 (PC) or 2 (SR); reg_value latched as write data.
REQ-019 PUSH_WR: mem_we=1 with latched address/data held until mem_ready=1; then PC phase -> PUSH_ADDR(SR), SR phase -> CLR_SR.
REQ-020 CLR_SR: regno=2, store=1, data = pushed SR AND 16'h0040 (only SCG0 kept).
REQ-021 VEC_RD: mem_re=1, mem_addr = VECTOR_BASE + 2*index until mem_ready; then store=1, regno=0, data=mem_rdata; irq_ack[index]=1 that cycle; -> IDLE.
REQ-022 POP_ADDR: regno=1, post_inc=1 for one cycle; reg_value (old SP) latched as read address.
REQ-023 POP_RD: mem_re=1 until mem_ready; then store=1 to SR (phase SR, -> POP_ADDR(PC)) or PC (phase PC, -> IDLE).
REQ-024 busy SHALL be 1 in every state except IDLE, and SHALL go 1 in the cycle after the IDLE exit decision.
REQ-025 Register-port outputs SHALL be 0 whenever not stated above; mem_we and mem_re never both 1.
REQ-026 Vector address arithmetic SHALL wrap modulo 2^16.
REQ-027 irq_req deasserting mid-sequence SHALL NOT abort; the latched index is vectored.

Reset
REQ-028 srst SHALL force IDLE in the next cycle, including mid-sequence; busy, irq_ack, mem_we, mem_re, store, sp_dec, post_inc and all latches 0.

Configuration
REQ-029 With IRQ_SEQ_RETI_EN defined, REQ-016/022/023 SHALL be present; without it, reti_req SHALL be ignored and POP states absent.

Structure
REQ-030 State encoding, register indices (PC=0, SP=1, SR=2) and GIE/SCG0 bit masks SHALL live in shared package msp430_pkg.
REQ-031 Priority encoder SHALL be sub-module irq_prio_enc (NUM_IRQ in, index and valid out, combinational).

Verification
REQ-032 SP=0x0400, PC=0xC010, SR=0x0008, irq_req[5]=1, boundary=1 -> writes 0x03FE=0xC010, 0x03FC=0x0008; read 0xFFEA; PC=rdata; SR=0x0000; SP=0x03FC; irq_ack[5] one pulse.
REQ-033 irq_req[2] and irq_req[9] together -> only irq_ack[9]; vector read at 0xFFF2.
REQ-034 flags[3]=0, irq_req=16'hFFFF, boundary=1 for 20 cycles -> busy stays 0, no bus activity.
REQ-035 mem_ready held 0 for 5 cycles during PUSH_WR -> mem_addr/mem_wdata/mem_we stable, no state advance.
REQ-036 srst pulsed in VEC_RD -> IDLE next cycle, no PC store, no irq_ack.
REQ-037 (IRQ_SEQ_RETI_EN) SP=0x03FC, mem[0x03FC]=0x0008, mem[0x03FE]=0xC010, reti_req -> SR=0x0008, PC=0xC010, SP=0x0400.

Source files
------------

// File: rtl/msp430_pkg.sv
// Shared definitions for the interrupt sequencer: FSM state encoding,
// register-file indices, status-register bit masks and vector address helper.
package msp430_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PUSH_ADDR = 3'd1,
        ST_PUSH_DATA = 3'd2,
        ST_PUSH_WR   = 3'd3,
        ST_CLR_SR    = 3'd4,
        ST_VEC_RD    = 3'd5,
        ST_POP_ADDR  = 3'd6,
        ST_POP_RD    = 3'd7
    } irq_seq_state_e;

    localparam logic [3:0]  REG_PC = 4'd0;
    localparam logic [3:0]  REG_SP = 4'd1;
    localparam logic [3:0]  REG_SR = 4'd2;

    localparam logic [15:0] SR_GIE_MASK  = 16'h0008;
    localparam logic [15:0] SR_SCG0_MASK = 16'h0040;

    localparam logic PHASE_PC = 1'b0;
    localparam logic PHASE_SR = 1'b1;

    // Word-sized vector slots; the sum wraps naturally at 16 bits.
    function automatic logic [15:0] vector_addr(input logic [15:0] base, input logic [3:0] idx);
        return base + {11'd0, idx, 1'b0};
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational priority encoder: reports the highest-index set request.
module irq_prio_enc #(
    parameter int NUM_IRQ = 16
) (
    input  logic [NUM_IRQ-1:0] req_i,
    output logic [3:0]         idx_o,
    output logic               valid_o
);

    // Ascending scan so the last (highest) set bit overrides lower ones.
    always_comb begin
        idx_o   = 4'd0;
        valid_o = 1'b0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            idx_o   = req_i[i] ? 4'(i) : idx_o;
            valid_o = valid_o | req_i[i];
        end
    end

endmodule

// File: rtl/irq_sequencer.sv
// Interrupt entry/return sequencer: pushes PC and SR, clears SR, fetches the vector.
// Define IRQ_SEQ_RETI_EN to add the RETI pop sequence (SR then PC).
module irq_sequencer
    import msp430_pkg::*;
#(
    parameter logic [15:0] VECTOR_BASE = 16'hFFE0,
    parameter int          NUM_IRQ     = 16
) (
    input  logic               clk,
    input  logic               srst,
    input  logic [NUM_IRQ-1:0] irq_req,
    output logic [NUM_IRQ-1:0] irq_ack,
    input  logic               boundary,
    input  logic               reti_req,
    output logic               busy,
    input  logic [15:0]        flags,
    output logic [3:0]         reg_regno,
    output logic               reg_store,
    output logic [15:0]        reg_data,
    input  logic [15:0]        reg_value,
    output logic [1:0]         reg_as,
    output logic               reg_bytemode,
    output logic               reg_post_inc,
    output logic               reg_sp_dec,
    output logic [15:0]        mem_addr,
    output logic [15:0]        mem_wdata,
    output logic               mem_we,
    output logic               mem_re,
    input  logic [15:0]        mem_rdata,
    input  logic               mem_ready
);

    irq_seq_state_e state_q, state_d;
    logic           phase_q, phase_d;
    logic [3:0]     idx_q, idx_d;
    logic [15:0]    addr_q, addr_d;
    logic [15:0]    data_q, data_d;

    logic [3:0]     enc_idx_s;
    logic           enc_valid_s;
    logic           irq_go_s;
    logic [15:0]    ack16_s;

    irq_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio (
        .req_i   (irq_req),
        .idx_o   (enc_idx_s),
        .valid_o (enc_valid_s)
    );

    assign irq_go_s     = boundary & (|(flags & SR_GIE_MASK)) & enc_valid_s;
    assign busy         = (state_q != ST_IDLE);
    assign irq_ack      = ack16_s[NUM_IRQ-1:0];
    assign reg_as       = 2'b00;
    assign reg_bytemode = 1'b0;

`ifndef IRQ_SEQ_RETI_EN
    logic unused_reti_s;
    assign unused_reti_s = reti_req;
`endif

    // State and latch registers.
    always_ff @(posedge clk) begin
        if (srst) begin
            state_q <= ST_IDLE;
            phase_q <= PHASE_PC;
            idx_q   <= 4'd0;
            addr_q  <= 16'd0;
            data_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // Next-state and output decode; srst silences every strobe in its own cycle.
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        idx_d        = idx_q;
        addr_d       = addr_q;
        data_d       = data_q;
        reg_regno    = REG_PC;
        reg_store    = 1'b0;
        reg_data     = 16'd0;
        reg_post_inc = 1'b0;
        reg_sp_dec   = 1'b0;
        mem_addr     = 16'd0;
        mem_wdata    = 16'd0;
        mem_we       = 1'b0;
        mem_re       = 1'b0;
        ack16_s      = 16'd0;
        if (srst) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
`ifdef IRQ_SEQ_RETI_EN
                    if (reti_req) begin
                        state_d = ST_POP_ADDR;
                        phase_d = PHASE_SR;
                    end else if (irq_go_s) begin
`else
                    if (irq_go_s) begin
`endif
                        state_d = ST_PUSH_ADDR;
                        phase_d = PHASE_PC;
                        idx_d   = enc_idx_s;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_PUSH_ADDR: begin
                    reg_regno  = REG_SP;
                    reg_sp_dec = 1'b1;
                    addr_d     = reg_value;
                    state_d    = ST_PUSH_DATA;
                end
                ST_PUSH_DATA: begin
                    reg_regno = (phase_q == PHASE_SR) ? REG_SR : REG_PC;
                    data_d    = reg_value;
                    state_d   = ST_PUSH_WR;
                end
                ST_PUSH_WR: begin
                    mem_we    = 1'b1;
                    mem_addr  = addr_q;
                    mem_wdata = data_q;
                    if (!mem_ready) begin
                        state_d = ST_PUSH_WR;
                    end else if (phase_q == PHASE_PC) begin
                        state_d = ST_PUSH_ADDR;
                        phase_d = PHASE_SR;
                    end else begin
                        state_d = ST_CLR_SR;
                    end
                end
                ST_CLR_SR: begin
                    // data_q still holds the SR just pushed.
                    reg_regno = REG_SR;
                    reg_store = 1'b1;
                    reg_data  = data_q & SR_SCG0_MASK;
                    state_d   = ST_VEC_RD;
                end
                ST_VEC_RD: begin
                    mem_re   = 1'b1;
                    mem_addr = vector_addr(VECTOR_BASE, idx_q);
                    if (mem_ready) begin
                        reg_regno = REG_PC;
                        reg_store = 1'b1;
                        reg_data  = mem_rdata;
                        ack16_s   = 16'd1 << idx_q;
                        state_d   = ST_IDLE;
                        phase_d   = PHASE_PC;
                    end else begin
                        state_d = ST_VEC_RD;
                    end
                end
`ifdef IRQ_SEQ_RETI_EN
                ST_POP_ADDR: begin
                    reg_regno    = REG_SP;
                    reg_post_inc = 1'b1;
                    addr_d       = reg_value;
                    state_d      = ST_POP_RD;
                end
                ST_POP_RD: begin
                    mem_re   = 1'b1;
                    mem_addr = addr_q;
                    if (!mem_ready) begin
                        state_d = ST_POP_RD;
                    end else if (phase_q == PHASE_SR) begin
                        reg_regno = REG_SR;
                        reg_store = 1'b1;
                        reg_data  = mem_rdata;
                        state_d   = ST_POP_ADDR;
                        phase_d   = PHASE_PC;
                    end else begin
                        reg_regno = REG_PC;
                        reg_store = 1'b1;
                        reg_data  = mem_rdata;
                        state_d   = ST_IDLE;
                    end
                end
`endif
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_sequencer.sv
// Self-checking bench for irq_sequencer: CPU register/memory model plus a bus/ack scoreboard.
module tb_irq_sequencer;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [15:0] data;
    } bus_t;

    logic        clk;
    logic        srst;
    logic [15:0] irq_req;
    logic [15:0] irq_ack;
    logic        boundary;
    logic        reti_req;
    logic        busy;
    logic [15:0] flags;
    logic [3:0]  reg_regno;
    logic        reg_store;
    logic [15:0] reg_data;
    logic [15:0] reg_value;
    logic [1:0]  reg_as;
    logic        reg_bytemode;
    logic        reg_post_inc;
    logic        reg_sp_dec;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [15:0] mem_rdata;
    logic        mem_ready;

    logic [15:0] pc_m, sp_m, sr_m;
    logic        ld_en;
    logic [15:0] ld_pc, ld_sp, ld_sr;
    logic [15:0] mem [logic [15:0]];

    bus_t        exp_q[$];
    logic [15:0] ack_q[$];
    int          n_total = 0;
    int          n_pass  = 0;
    int          ack_cnt = 0;
    int          ack_base;

    irq_sequencer dut (
        .clk          (clk),
        .srst         (srst),
        .irq_req      (irq_req),
        .irq_ack      (irq_ack),
        .boundary     (boundary),
        .reti_req     (reti_req),
        .busy         (busy),
        .flags        (flags),
        .reg_regno    (reg_regno),
        .reg_store    (reg_store),
        .reg_data     (reg_data),
        .reg_value    (reg_value),
        .reg_as       (reg_as),
        .reg_bytemode (reg_bytemode),
        .reg_post_inc (reg_post_inc),
        .reg_sp_dec   (reg_sp_dec),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .mem_re       (mem_re),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // CPU register file model: SP-2 is visible during the decrement cycle.
    assign flags = sr_m;
    always_comb begin
        reg_value = 16'h0000;
        if (reg_regno == 4'd1 && reg_sp_dec) reg_value = sp_m - 16'd2;
        else if (reg_regno == 4'd0)          reg_value = pc_m;
        else if (reg_regno == 4'd1)          reg_value = sp_m;
        else if (reg_regno == 4'd2)          reg_value = sr_m;
    end

    always_comb begin
        mem_rdata = 16'h0000;
        if (mem_re && mem.exists(mem_addr)) mem_rdata = mem[mem_addr];
    end

    always @(posedge clk) begin
        if (ld_en) begin
            pc_m <= ld_pc;
            sp_m <= ld_sp;
            sr_m <= ld_sr;
        end else begin
            if (reg_sp_dec)   sp_m <= sp_m - 16'd2;
            if (reg_post_inc) sp_m <= sp_m + 16'd2;
            if (reg_store) begin
                case (reg_regno)
                    4'd0:    pc_m <= reg_data;
                    4'd1:    sp_m <= reg_data;
                    4'd2:    sr_m <= reg_data;
                    default: ;
                endcase
            end
        end
    end

    // Scoreboard: completed bus transfers and acks are compared in order.
    always @(negedge clk) begin
        if (!srst) begin
            check("we_re_excl", 32'(mem_we & mem_re), 32'd0);
            if ((mem_we || mem_re) && mem_ready) begin
                if (exp_q.size() == 0) begin
                    check("bus_unexpected", 32'(exp_q.size()), 32'd1);
                end else begin
                    check("bus_dir", 32'(mem_we), 32'(exp_q[0].we));
                    check("bus_addr", 32'(mem_addr), 32'(exp_q[0].addr));
                    if (exp_q[0].we) check("bus_wdata", 32'(mem_wdata), 32'(exp_q[0].data));
                    void'(exp_q.pop_front());
                end
            end
            if (irq_ack != 16'h0000) begin
                ack_cnt <= ack_cnt + 1;
                if (ack_q.size() == 0) begin
                    check("ack_unexpected", 32'(irq_ack), 32'd0);
                end else begin
                    check("ack_value", 32'(irq_ack), 32'(ack_q[0]));
                    void'(ack_q.pop_front());
                end
            end
        end
    end

    task automatic set_regs(input logic [15:0] pc, input logic [15:0] sp, input logic [15:0] sr);
        ld_pc = pc;
        ld_sp = sp;
        ld_sr = sr;
        ld_en = 1'b1;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    task automatic push_bus(input logic we, input logic [15:0] a, input logic [15:0] d);
        exp_q.push_back({we, a, d});
    endtask

    task automatic start_irq(input logic [15:0] req);
        logic seen;
        seen     = 1'b0;
        irq_req  = req;
        boundary = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (busy) begin
                seen = 1'b1;
                break;
            end
        end
        check("entry_busy", 32'(seen), 32'd1);
        irq_req  = 16'h0000;
        boundary = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check("idle_reached", 32'(busy), 32'd0);
    endtask

    task automatic end_checks(input logic [15:0] pc, input logic [15:0] sp, input logic [15:0] sr, input int acks);
        @(posedge clk); #1;
        check("final_pc", 32'(pc_m), 32'(pc));
        check("final_sp", 32'(sp_m), 32'(sp));
        check("final_sr", 32'(sr_m), 32'(sr));
        check("bus_q_drained", 32'(exp_q.size()), 32'd0);
        check("ack_q_drained", 32'(ack_q.size()), 32'd0);
        check("ack_count", 32'(ack_cnt - ack_base), 32'(acks));
    endtask

    initial begin
        logic found;
        srst      = 1'b1;
        irq_req   = 16'h0000;
        boundary  = 1'b0;
        reti_req  = 1'b0;
        mem_ready = 1'b1;
        ld_en     = 1'b0;
        ld_pc     = 16'h0000;
        ld_sp     = 16'h0000;
        ld_sr     = 16'h0000;
        mem[16'hFFEA] = 16'h1234;
        mem[16'hFFF2] = 16'hABCD;
        mem[16'hFFE0] = 16'h5555;
        mem[16'hFFE6] = 16'h7777;
        mem[16'h03FC] = 16'h0008;
        mem[16'h03FE] = 16'hC010;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ack", 32'(irq_ack), 32'd0);
        check("rst_bus", 32'({mem_we, mem_re}), 32'd0);
        check("rst_regport", 32'({reg_store, reg_sp_dec, reg_post_inc, reg_as, reg_bytemode}), 32'd0);
        srst = 1'b0;

        // Line 5 entry; irq_req drops right after entry and must not abort.
        set_regs(16'hC010, 16'h0400, 16'h0008);
        ack_base = ack_cnt;
        push_bus(1'b1, 16'h03FE, 16'hC010);
        push_bus(1'b1, 16'h03FC, 16'h0008);
        push_bus(1'b0, 16'hFFEA, 16'h0000);
        ack_q.push_back(16'h0020);
        start_irq(16'h0020);
        wait_idle(100);
        end_checks(16'h1234, 16'h03FC, 16'h0000, 1);

        // Priority: lines 2 and 9 together, SCG0 survives the SR clear.
        set_regs(16'hC100, 16'h0400, 16'h0048);
        ack_base = ack_cnt;
        push_bus(1'b1, 16'h03FE, 16'hC100);
        push_bus(1'b1, 16'h03FC, 16'h0048);
        push_bus(1'b0, 16'hFFF2, 16'h0000);
        ack_q.push_back(16'h0200);
        start_irq(16'h0204);
        wait_idle(100);
        end_checks(16'hABCD, 16'h03FC, 16'h0040, 1);

        // Write stall: mem_ready low for 5 cycles in PUSH_WR.
        set_regs(16'h2222, 16'h0200, 16'h0008);
        ack_base  = ack_cnt;
        mem_ready = 1'b0;
        push_bus(1'b1, 16'h01FE, 16'h2222);
        push_bus(1'b1, 16'h01FC, 16'h0008);
        push_bus(1'b0, 16'hFFE0, 16'h0000);
        ack_q.push_back(16'h0001);
        start_irq(16'h0001);
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (mem_we) begin
                found = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check("stall_reached_wr", 32'(found), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("stall_we", 32'(mem_we), 32'd1);
            check("stall_addr", 32'(mem_addr), 32'h01FE);
            check("stall_wdata", 32'(mem_wdata), 32'h2222);
            check("stall_sp", 32'(sp_m), 32'h01FE);
        end
        mem_ready = 1'b1;
        wait_idle(100);
        end_checks(16'h5555, 16'h01FC, 16'h0000, 1);

        // srst while waiting in VEC_RD: no PC store, no ack, idle next cycle.
        set_regs(16'h3333, 16'h0300, 16'h0008);
        ack_base = ack_cnt;
        push_bus(1'b1, 16'h02FE, 16'h3333);
        push_bus(1'b1, 16'h02FC, 16'h0008);
        start_irq(16'h0008);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (reg_store && reg_regno == 4'd2) begin
                found = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check("reached_clr_sr", 32'(found), 32'd1);
        mem_ready = 1'b0;
        @(posedge clk); #1;
        check("vec_rd_re", 32'(mem_re), 32'd1);
        check("vec_rd_addr", 32'(mem_addr), 32'hFFE6);
        srst      = 1'b1;
        mem_ready = 1'b1;
        #1;
        check("srst_no_ack", 32'(irq_ack), 32'd0);
        check("srst_no_store", 32'(reg_store), 32'd0);
        @(posedge clk); #1;
        srst = 1'b0;
        check("srst_idle", 32'({busy, mem_re, mem_we}), 32'd0);
        end_checks(16'h3333, 16'h02FC, 16'h0000, 0);

        // GIE clear: requests and boundary for 20 cycles, nothing happens.
        set_regs(16'h4444, 16'h0400, 16'h0000);
        irq_req  = 16'hFFFF;
        boundary = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("gie_off_quiet", 32'({busy, mem_we, mem_re}), 32'd0);
        end
        boundary = 1'b0;
        set_regs(16'h4444, 16'h0400, 16'h0008);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("no_boundary_quiet", 32'({busy, mem_we, mem_re}), 32'd0);
        end
        irq_req = 16'h0000;

`ifdef IRQ_SEQ_RETI_EN
        // RETI coinciding with a pending interrupt: RETI wins.
        set_regs(16'h0000, 16'h03FC, 16'h0008);
        ack_base = ack_cnt;
        push_bus(1'b0, 16'h03FC, 16'h0000);
        push_bus(1'b0, 16'h03FE, 16'h0000);
        reti_req = 1'b1;
        irq_req  = 16'h0002;
        boundary = 1'b1;
        @(posedge clk); #1;
        reti_req = 1'b0;
        irq_req  = 16'h0000;
        boundary = 1'b0;
        check("reti_busy", 32'(busy), 32'd1);
        wait_idle(100);
        end_checks(16'hC010, 16'h0400, 16'h0008, 0);
`else
        set_regs(16'h4444, 16'h0400, 16'h0000);
        reti_req = 1'b1;
        @(posedge clk); #1;
        reti_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("reti_ignored", 32'({busy, mem_re, reg_post_inc}), 32'd0);
            @(posedge clk); #1;
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
